// File: rtl/fv_rand_pkg.sv
// -----------------------------------------------------------------------------
// fv_rand_pkg
// Shared constants and types for the FV random-source arbiter:
//   - LFSR width and Fibonacci tap positions (x^64 + x^63 + x^61 + x^60 + 1 form)
//   - default reset seed
//   - arbiter FSM state type
//   - single-step LFSR helper, shared by the LFSR block
// -----------------------------------------------------------------------------
package fv_rand_pkg;

    localparam int LFSR_W = 64;

    localparam int TAP_A = 63;
    localparam int TAP_B = 62;
    localparam int TAP_C = 60;
    localparam int TAP_D = 59;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 64'hFEDC_BA98_7654_3210;

    typedef enum logic [0:0] {
        ST_WARMUP,
        ST_SERVE
    } rand_state_e;

    // One Fibonacci step: shift left, feedback XOR enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D]};
    endfunction

endpackage

// File: rtl/lfsr64_step_en.sv
// -----------------------------------------------------------------------------
// lfsr64_step_en
// 64-bit Fibonacci LFSR that only advances when asked to, with a parallel load.
// Load has priority over step.
//
// Ports:
//   clk       in   1    clock
//   s_rst_n   in   1    async active-low reset (state returns to RESET_VAL)
//   step      in   1    advance the LFSR by one step this cycle
//   load      in   1    replace the state with load_val this cycle
//   load_val  in   64   value to load (caller guarantees non-zero)
//   state     out  64   current LFSR state
// -----------------------------------------------------------------------------
module lfsr64_step_en
    import fv_rand_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_VAL = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              s_rst_n,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_reg;

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_reg <= RESET_VAL;
        end else if (load) begin
            state_reg <= load_val;
        end else if (step) begin
            state_reg <= lfsr_next(state_reg);
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/lfsr_rand_arbiter.sv
// -----------------------------------------------------------------------------
// lfsr_rand_arbiter
// Shares one 64-bit LFSR between NUM_REQ consumers with round-robin arbitration.
// Each grant hands out exactly one word and advances the LFSR once, so the word
// sequence depends only on the seed. After reset or a reseed the LFSR is run
// WARMUP_STEPS times with no grants to discard the early, low-entropy states.
//
// Ports:
//   clk        in   1        clock
//   s_rst_n    in   1        async active-low reset
//   req        in   NUM_REQ  level request; held high = wants another word
//   seed_load  in   1        pulse: load seed_val (or SEED if zero), restart warm-up
//   seed_val   in   64       new seed, sampled with seed_load
//   gnt        out  NUM_REQ  registered one-hot grant, rand_data valid with it
//   rand_data  out  64       registered word belonging to the grant
//   busy       out  1        high while warming up (no grants possible)
// -----------------------------------------------------------------------------
module lfsr_rand_arbiter
    import fv_rand_pkg::*;
#(
    parameter int                NUM_REQ      = 4,
    parameter logic [LFSR_W-1:0] SEED         = DEFAULT_SEED,
    parameter int                WARMUP_STEPS = 16
) (
    input  logic               clk,
    input  logic               s_rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               seed_load,
    input  logic [LFSR_W-1:0]  seed_val,
    output logic [NUM_REQ-1:0] gnt,
    output logic [LFSR_W-1:0]  rand_data,
    output logic               busy
);

    localparam int                PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]    NUM_EXT   = (PTR_W + 1)'(NUM_REQ);
    localparam logic [7:0]        WARM_INIT = 8'(WARMUP_STEPS);

    rand_state_e        state_reg;
    logic [7:0]         warm_cnt_reg;
    logic [PTR_W-1:0]   rr_ptr_reg;
    logic [NUM_REQ-1:0] gnt_reg;
    logic [LFSR_W-1:0]  rand_data_reg;
    logic               busy_reg;

    logic [LFSR_W-1:0]  lfsr_state;
    logic [LFSR_W-1:0]  lfsr_load_val;
    logic               lfsr_step;

    logic [PTR_W:0]     idx_ext;
    logic [PTR_W-1:0]   winner_next;
    logic               req_hit;
    logic               grant_fire;
    logic [NUM_REQ-1:0] gnt_next;
    logic [PTR_W-1:0]   rr_ptr_next;

    // -------------------------------------------------------------------------
    // Round-robin search: first asserted request at rr_ptr, rr_ptr+1, ... mod N.
    // -------------------------------------------------------------------------
    always_comb begin
        req_hit     = 1'b0;
        winner_next = '0;
        idx_ext     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_ext = {1'b0, rr_ptr_reg} + (PTR_W + 1)'(k);
            if (idx_ext >= NUM_EXT) begin
                idx_ext = idx_ext - NUM_EXT;
            end
            if (!req_hit && req[idx_ext[PTR_W-1:0]]) begin
                req_hit     = 1'b1;
                winner_next = idx_ext[PTR_W-1:0];
            end
        end
    end

    // A reseed in the same cycle suppresses the grant so no word from the old
    // seed leaks out after the consumer asked for a fresh sequence.
    assign grant_fire  = (state_reg == ST_SERVE) && req_hit && !seed_load;
    assign rr_ptr_next = (winner_next == LAST_IDX) ? '0 : winner_next + 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign gnt_next[gi] = grant_fire && (winner_next == PTR_W'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // LFSR: steps during warm-up (while steps remain) and once per grant.
    // An all-zero seed would lock the LFSR, so it is replaced by SEED.
    // -------------------------------------------------------------------------
    assign lfsr_load_val = (seed_val == '0) ? SEED : seed_val;
    assign lfsr_step     = !seed_load &&
                           (((state_reg == ST_WARMUP) && (warm_cnt_reg != 8'd0)) || grant_fire);

    lfsr64_step_en #(
        .RESET_VAL (SEED)
    ) u_lfsr (
        .clk      (clk),
        .s_rst_n  (s_rst_n),
        .step     (lfsr_step),
        .load     (seed_load),
        .load_val (lfsr_load_val),
        .state    (lfsr_state)
    );

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_reg     <= ST_WARMUP;
            warm_cnt_reg  <= WARM_INIT;
            rr_ptr_reg    <= '0;
            gnt_reg       <= '0;
            rand_data_reg <= '0;
            busy_reg      <= 1'b1;
        end else begin
            // gnt_next is already zero outside SERVE and on a reseed cycle.
            gnt_reg <= gnt_next;
            if (seed_load) begin
                state_reg    <= ST_WARMUP;
                warm_cnt_reg <= WARM_INIT;
                busy_reg     <= 1'b1;
            end else begin
                case (state_reg)
                    ST_WARMUP: begin
                        if (warm_cnt_reg != 8'd0) begin
                            warm_cnt_reg <= warm_cnt_reg - 8'd1;
                        end
                        // Leave on the cycle that performs the last step, or
                        // immediately when no warm-up steps were configured.
                        if (warm_cnt_reg <= 8'd1) begin
                            state_reg <= ST_SERVE;
                            busy_reg  <= 1'b0;
                        end
                    end
                    ST_SERVE: begin
                        if (grant_fire) begin
                            rand_data_reg <= lfsr_state;
                            rr_ptr_reg    <= rr_ptr_next;
                        end
                    end
                endcase
            end
        end
    end

    assign gnt       = gnt_reg;
    assign rand_data = rand_data_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lfsr_rand_arbiter
// Two instances (no warm-up, and a short warm-up) driven by the same stimulus,
// each compared every cycle against a behavioural model of the arbiter.
// -----------------------------------------------------------------------------
module tb_lfsr_rand_arbiter;

    localparam int          N    = 4;
    localparam logic [63:0] SEED = 64'hFEDC_BA98_7654_3210;
    localparam int          WS0  = 0;
    localparam int          WS1  = 5;

    logic         clk       = 1'b0;
    logic         s_rst_n   = 1'b1;
    logic [N-1:0] req       = '0;
    logic         seed_load = 1'b0;
    logic [63:0]  seed_val  = '0;

    logic [N-1:0] gnt0, gnt1;
    logic [63:0]  data0, data1;
    logic         busy0, busy1;

    always #5 clk = ~clk;

    lfsr_rand_arbiter #(
        .NUM_REQ      (N),
        .SEED         (SEED),
        .WARMUP_STEPS (WS0)
    ) u_dut0 (
        .clk       (clk),
        .s_rst_n   (s_rst_n),
        .req       (req),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .gnt       (gnt0),
        .rand_data (data0),
        .busy      (busy0)
    );

    lfsr_rand_arbiter #(
        .NUM_REQ      (N),
        .SEED         (SEED),
        .WARMUP_STEPS (WS1)
    ) u_dut1 (
        .clk       (clk),
        .s_rst_n   (s_rst_n),
        .req       (req),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .gnt       (gnt1),
        .rand_data (data1),
        .busy      (busy1)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0]  m_lfsr [2];
    logic [63:0]  m_data [2];
    logic [N-1:0] m_gnt  [2];
    logic         m_busy [2];
    int           m_ptr  [2];
    int           m_warm [2];
    int           ws     [2];

    function automatic logic [63:0] lfsr_next(input logic [63:0] x);
        return {x[62:0], x[63] ^ x[62] ^ x[60] ^ x[59]};
    endfunction

    function automatic logic [63:0] warmed(input logic [63:0] s, input int n);
        logic [63:0] v;
        v = s;
        for (int i = 0; i < n; i++) v = lfsr_next(v);
        return v;
    endfunction

    // The warm-up is modelled as an idle window of max(WS,1) cycles, with the
    // LFSR already advanced WS times at (re)seed time.
    task automatic model_reset(input int m);
        m_lfsr[m] = warmed(SEED, ws[m]);
        m_warm[m] = (ws[m] > 0) ? ws[m] : 1;
        m_busy[m] = 1'b1;
        m_gnt[m]  = '0;
        m_data[m] = '0;
        m_ptr[m]  = 0;
    endtask

    task automatic model_tick(input int m);
        int w;
        int i;
        w = -1;
        if (seed_load) begin
            m_lfsr[m] = warmed((seed_val == 64'd0) ? SEED : seed_val, ws[m]);
            m_warm[m] = (ws[m] > 0) ? ws[m] : 1;
            m_busy[m] = 1'b1;
            m_gnt[m]  = '0;
        end else if (m_busy[m]) begin
            m_warm[m]--;
            if (m_warm[m] == 0) m_busy[m] = 1'b0;
            m_gnt[m] = '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                i = (m_ptr[m] + k) % N;
                if (w < 0 && req[i]) w = i;
            end
            if (w >= 0) begin
                m_gnt[m]  = N'(1 << w);
                m_data[m] = m_lfsr[m];
                m_lfsr[m] = lfsr_next(m_lfsr[m]);
                m_ptr[m]  = (w + 1) % N;
            end else begin
                m_gnt[m] = '0;
            end
        end
    endtask

    task automatic check_all();
        check_val("gnt0",    64'(gnt0),  64'(m_gnt[0]));
        check_val("data0",   data0,      m_data[0]);
        check_val("busy0",   64'(busy0), 64'(m_busy[0]));
        check_val("onehot0", 64'($onehot0(gnt0)), 64'd1);
        check_val("gnt1",    64'(gnt1),  64'(m_gnt[1]));
        check_val("data1",   data1,      m_data[1]);
        check_val("busy1",   64'(busy1), 64'(m_busy[1]));
        check_val("onehot1", 64'($onehot0(gnt1)), 64'd1);
        if (gnt0 != '0 || gnt1 != '0)
            $display("txn t=%0t req=%b gnt0=%b data0=%h gnt1=%b data1=%h",
                     $time, req, gnt0, data0, gnt1, data1);
    endtask

    // Drive inputs, take one clock edge, advance the model, check #1 later.
    task automatic do_cycle(input logic [N-1:0] r, input logic sl, input logic [63:0] sv);
        req       = r;
        seed_load = sl;
        seed_val  = sv;
        @(posedge clk);
        if (s_rst_n) begin
            model_tick(0);
            model_tick(1);
        end
        #1;
        check_all();
        seed_load = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [63:0] seen_q[$];
    logic [63:0] first_word;
    logic [N-1:0] rnd_req;
    logic rnd_sl;
    logic [63:0] rnd_sv;
    int busy_cnt;
    bit got_word;
    bit dup;

    initial begin
        ws[0] = WS0;
        ws[1] = WS1;

        // Reset state
        #1 s_rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1 s_rst_n = 1'b1;

        // Test 1: no-warm-up instance serves requester 0 straight after reset
        do_cycle(4'b0001, 1'b0, 64'd0);
        check_val("t1_busy_low", 64'(busy0), 64'd0);
        do_cycle(4'b0001, 1'b0, 64'd0);
        check_val("t1_gnt_a",  64'(gnt0), 64'b0001);
        check_val("t1_word_a", data0, 64'hFEDC_BA98_7654_3210);
        do_cycle(4'b0001, 1'b0, 64'd0);
        check_val("t1_gnt_b",  64'(gnt0), 64'b0001);
        check_val("t1_word_b", data0, 64'hFDB9_7530_ECA8_6420);

        // Test 2: all requesting -> rotation starting after requester 0, no repeats
        seen_q.delete();
        for (int i = 0; i < 8; i++) begin
            do_cycle(4'b1111, 1'b0, 64'd0);
            check_val("t2_rot", 64'(gnt0), 64'(4'b0001 << ((1 + i) % N)));
            dup = 1'b0;
            foreach (seen_q[j]) if (seen_q[j] == data0) dup = 1'b1;
            check_val("t2_norepeat", 64'(dup), 64'd0);
            seen_q.push_back(data0);
        end

        // Test 3: pointer at 2, only 0/1 requesting -> wrap to 0 then 1
        do_cycle(4'b0010, 1'b0, 64'd0);
        check_val("t3_set_ptr", 64'(gnt0), 64'b0010);
        do_cycle(4'b0011, 1'b0, 64'd0);
        check_val("t3_wrap", 64'(gnt0), 64'b0001);
        do_cycle(4'b0011, 1'b0, 64'd0);
        check_val("t3_next", 64'(gnt0), 64'b0010);

        // Test 4: zero seed during SERVE -> default seed, warm-up, no grant
        busy_cnt   = 0;
        got_word   = 1'b0;
        first_word = '0;
        do_cycle(4'b1111, 1'b1, 64'd0);
        check_val("t4_no_gnt0", 64'(gnt0), 64'd0);
        check_val("t4_no_gnt1", 64'(gnt1), 64'd0);
        if (busy1) busy_cnt++;
        for (int i = 0; i < 10; i++) begin
            do_cycle(4'b1111, 1'b0, 64'd0);
            if (busy1) busy_cnt++;
            if (!got_word && gnt1 != '0) begin
                got_word   = 1'b1;
                first_word = data1;
            end
        end
        check_val("t4_busy_cycles", 64'(busy_cnt), 64'(WS1));
        check_val("t4_got_word",    64'(got_word), 64'd1);
        check_val("t4_first_word",  first_word, warmed(SEED, WS1));

        // Test 5: asynchronous reset in the middle of a burst
        do_cycle(4'b1111, 1'b0, 64'd0);
        do_cycle(4'b1111, 1'b0, 64'd0);
        #2 s_rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        check_val("t5_gnt0_rst",  64'(gnt0), 64'd0);
        check_val("t5_data0_rst", data0, 64'd0);
        check_val("t5_busy1_rst", 64'(busy1), 64'd1);
        check_all();
        repeat (2) @(posedge clk);
        #1 s_rst_n = 1'b1;
        do_cycle(4'b1111, 1'b0, 64'd0);
        do_cycle(4'b1111, 1'b0, 64'd0);
        check_val("t5_first_word", data0, SEED);
        for (int i = 0; i < 6; i++) do_cycle(4'b1111, 1'b0, 64'd0);

        // Test 6: idle requests hold everything; next grant continues the sequence
        for (int i = 0; i < 10; i++) do_cycle(4'b0000, 1'b0, 64'd0);
        do_cycle(4'b0100, 1'b0, 64'd0);

        // Random traffic with occasional reseeds (some with a zero seed)
        for (int i = 0; i < 300; i++) begin
            rnd_req = N'($urandom_range(0, (1 << N) - 1));
            rnd_sl  = ($urandom_range(0, 39) == 0);
            rnd_sv  = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'd0;
            do_cycle(rnd_req, rnd_sl, rnd_sv);
        end
        for (int i = 0; i < 8; i++) do_cycle(4'b1111, 1'b0, 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
